// File: rtl/fb_scanout.sv
// Framebuffer scanout: 640x480@60 VGA timing, pixel fetch, palette, buffer swap.
// Define PALETTE_EN for a writable 16x12 palette; otherwise grey-scale map.
module fb_scanout #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        areset,
  output logic [9:0]  rd_x,
  output logic [9:0]  rd_y,
  output logic        rd_buf,
  input  logic [3:0]  rd_data,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        front_sel,
  output logic        frame_start,
  output logic        vblank,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [11:0] pal_data
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [11:0]   pix_rgb;

  logic pix_en;
  logic h_end;
  logic v_end;
  logic visible;
  logic swap_tick;
  logic frame_tick;

  assign pix_en     = (div == DIV_MAX);
  assign h_end      = (h_cnt == 10'd799);
  assign v_end      = (v_cnt == 10'd524);
  assign visible    = (h_cnt < 10'd640) && (v_cnt < 10'd480);
  assign swap_tick  = pix_en && h_end && (v_cnt == 10'd479);
  assign frame_tick = pix_en && h_end && v_end;

  assign rd_x   = visible ? h_cnt : 10'd0;
  assign rd_y   = visible ? v_cnt : 10'd0;
  assign rd_buf = front_sel;

  always_ff @(posedge clk) begin
    if (areset) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vblank      <= 1'b0;
      rgb         <= '0;
      front_sel   <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= pix_en ? '0 : div + DW'(1);
      swap_ack    <= swap_tick && swap_req;
      frame_start <= frame_tick;
      if (swap_tick && swap_req)
        front_sel <= !front_sel;
      if (pix_en) begin
        h_cnt <= h_end ? 10'd0 : h_cnt + 10'd1;
        if (h_end)
          v_cnt <= v_end ? 10'd0 : v_cnt + 10'd1;
        // Outputs lag the counters by one pixel period.
        rgb    <= visible ? pix_rgb : 12'd0;
        hsync  <= !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
        vsync  <= !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
        vblank <= (v_cnt >= 10'd480);
      end
    end
  end

`ifdef PALETTE_EN
  logic [11:0] pal [16];

  always_ff @(posedge clk) begin
    if (areset) begin
      for (int i = 0; i < 16; i++)
        pal[i] <= {3{4'(i)}};
    end else if (pal_we) begin
      pal[pal_idx] <= pal_data;
    end
  end

  assign pix_rgb = pal[rd_data];
`else
  logic unused_pal;

  assign unused_pal = ^{pal_we, pal_idx, pal_data};
  assign pix_rgb    = {3{rd_data}};
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: arithmetic timing model, RAM responder, random palette.
// Build with PALETTE_EN defined to exercise the palette variant.
module tb_fb_scanout;

  localparam int D = 2;
  localparam longint FRAME = 64'(800 * 525 * D);

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [9:0]  rd_x;
  logic [9:0]  rd_y;
  logic        rd_buf;
  logic [3:0]  rd_data = 4'd0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        front_sel;
  logic        frame_start;
  logic        vblank;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = 4'd0;
  logic [11:0] pal_data = 12'd0;

  int total = 0;
  int bad = 0;
  int key = 0;

  always #5 clk = ~clk;

  fb_scanout #(.CLK_DIV(D)) dut (
    .clk(clk), .areset(areset),
    .rd_x(rd_x), .rd_y(rd_y), .rd_buf(rd_buf), .rd_data(rd_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_sel(front_sel),
    .frame_start(frame_start), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data)
  );

  // Reference model: t = clk edges since the last reset edge
  longint      t = 0;
  logic        front_m = 1'b0;
  logic        ack_m = 1'b0;
  logic        fs_m = 1'b0;
  logic [11:0] rgb_m = 12'd0;
  logic [11:0] pal_m [16];

  function automatic int px_h(longint tt);
    return int'((tt / D) % 800);
  endfunction

  function automatic int px_v(longint tt);
    return int'(((tt / D) / 800) % 525);
  endfunction

  function automatic bit vis(int h, int v);
    return (h < 640) && (v < 480);
  endfunction

  function automatic logic [3:0] ram(int x, int y, logic b);
    if (x == 0 && y == 0)
      return 4'hF;
    return 4'((x ^ (y * 3)) + key + (b ? 9 : 0));
  endfunction

  function automatic logic [11:0] map_m(logic [3:0] d);
`ifdef PALETTE_EN
    return pal_m[d];
`else
    return {d, d, d};
`endif
  endfunction

  // {hsync, vsync, vblank} expected during cycle tt
  function automatic logic [2:0] exp_sync(longint tt);
    longint q;
    int h;
    int v;
    if (tt / D == 0)
      return 3'b110;
    q = tt / D - 1;
    h = int'(q % 800);
    v = int'((q / 800) % 525);
    return {!(h >= 656 && h <= 751), !(v >= 490 && v <= 491), v >= 480};
  endfunction

  function automatic logic [19:0] exp_rd(longint tt);
    int h;
    int v;
    h = px_h(tt);
    v = px_v(tt);
    if (!vis(h, v))
      return 20'd0;
    return {10'(v), 10'(h)};
  endfunction

  always @(posedge clk) begin
    if (areset) begin
      t       <= 0;
      front_m <= 1'b0;
      ack_m   <= 1'b0;
      fs_m    <= 1'b0;
      rgb_m   <= 12'd0;
      for (int i = 0; i < 16; i++)
        pal_m[i] <= {3{4'(i)}};
    end else begin
      t     <= t + 1;
      ack_m <= 1'b0;
      fs_m  <= 1'b0;
      if (t % D == D - 1) begin
        rgb_m <= vis(px_h(t), px_v(t))
               ? map_m(ram(px_h(t), px_v(t), front_m)) : 12'd0;
        if (px_h(t) == 799 && px_v(t) == 479 && swap_req) begin
          front_m <= !front_m;
          ack_m   <= 1'b1;
        end
        if (px_h(t) == 799 && px_v(t) == 524)
          fs_m <= 1'b1;
      end
      if (pal_we)
        pal_m[pal_idx] <= pal_data;
    end
  end

  // Framebuffer RAM: one clk read latency
  always @(posedge clk)
    rd_data <= ram(int'(rd_x), int'(rd_y), rd_buf);

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({hsync, vsync, vblank, rgb} !== {3'b110, 12'd0}) begin
      bad++;
      $display("FAIL reset_sync_rgb got=%b/%h want=110/000",
               {hsync, vsync, vblank}, rgb);
    end
    total++;
    if ({front_sel, rd_buf, swap_ack, frame_start} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0000",
               {front_sel, rd_buf, swap_ack, frame_start});
    end
    total++;
    if ({rd_y, rd_x} !== 20'd0) begin
      bad++;
      $display("FAIL reset_addr got=%0d,%0d want=0,0", rd_x, rd_y);
    end
    areset = 1'b0;
  endtask

  task automatic test_sync_lines;
    int low1 = 0;
    int low2 = 0;
    int nerr = 0;
    longint fall[$];
    logic prev = 1'b1;
    repeat (2 * 800 * D) begin
      @(negedge clk);
      if (nerr < 5) begin
        total++;
        if ({hsync, vsync, vblank} !== exp_sync(t)) begin
          bad++;
          nerr++;
          $display("FAIL sync t=%0d got=%b want=%b",
                   t, {hsync, vsync, vblank}, exp_sync(t));
        end
      end
      if (hsync === 1'b0) begin
        if (t <= 800 * D) low1++;
        else low2++;
        if (prev === 1'b1) fall.push_back(t);
      end
      prev = hsync;
    end
    total++;
    if (low1 != 96 * D || low2 != 96 * D) begin
      bad++;
      $display("FAIL hsync_low got=%0d,%0d want=%0d", low1, low2, 96 * D);
    end
    total++;
    if (fall.size() != 2 || fall[1] - fall[0] != 64'(800 * D)) begin
      bad++;
      $display("FAIL hsync_period falls=%0d want=2 spacing=%0d",
               fall.size(), 800 * D);
    end
  endtask

  task automatic test_pixels;
    int nerr = 0;
    int n_vis = 0;
    @(negedge clk);
    pal_we   = 1'b1;
    pal_idx  = 4'd3;
    pal_data = 12'hF00;
    while (px_v(t) < 12) begin
      @(negedge clk);
      if (nerr < 5) begin
        total++;
        if (rgb !== rgb_m || {rd_y, rd_x} !== exp_rd(t) ||
            rd_buf !== front_m) begin
          bad++;
          nerr++;
          $display("FAIL pixel t=%0d rgb=%h/%h addr=%0d,%0d want %h",
                   t, rgb, rgb_m, rd_x, rd_y, exp_rd(t));
        end
      end
      if (rgb_m != 12'd0) n_vis++;
      pal_we = ($urandom_range(0, 49) == 0);
      pal_idx = 4'($urandom_range(0, 15));
      if (pal_idx == 4'd3) pal_idx = 4'd4;
      pal_data = 12'($urandom);
    end
    pal_we = 1'b0;
    total++;
    if (n_vis < 1000) begin
      bad++;
      $display("FAIL pixel_coverage got=%0d want>=1000", n_vis);
    end
  endtask

  task automatic test_reset_midframe;
    longint target;
    target = 64'(200 * 800 + 300) * D;
    while (t < target) @(negedge clk);
    swap_req = 1'b1;
    areset   = 1'b1;
    @(negedge clk);
    total++;
    if ({hsync, vsync, rgb} !== {2'b11, 12'd0} || {rd_y, rd_x} !== 20'd0) begin
      bad++;
      $display("FAIL midreset_out got=%b/%h addr=%0d,%0d want=11/000 0,0",
               {hsync, vsync}, rgb, rd_x, rd_y);
    end
    total++;
    if ({front_sel, swap_ack, frame_start} !== 3'b000) begin
      bad++;
      $display("FAIL midreset_ctrl got=%b want=000",
               {front_sel, swap_ack, frame_start});
    end
    areset   = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic test_swap_frame;
    int nerr = 0;
    int acks = 0;
    int fs_n = 0;
    int vs_low = 0;
    longint fs_t = -1;
    bit req_on = 0;
    bit acked = 0;
    while (t < FRAME + 20 * D) begin
      @(negedge clk);
      if (nerr < 5) begin
        total++;
        if ({front_sel, rd_buf, swap_ack, frame_start} !==
            {front_m, front_m, ack_m, fs_m} ||
            {hsync, vsync, vblank} !== exp_sync(t) || rgb !== rgb_m ||
            {rd_y, rd_x} !== exp_rd(t)) begin
          bad++;
          nerr++;
          $display("FAIL frame t=%0d ctrl=%b want=%b sync=%b want=%b rgb=%h want=%h",
                   t, {front_sel, rd_buf, swap_ack, frame_start},
                   {front_m, front_m, ack_m, fs_m},
                   {hsync, vsync, vblank}, exp_sync(t), rgb, rgb_m);
        end
      end
      if (swap_ack === 1'b1) acks++;
      if (frame_start === 1'b1) begin
        fs_n++;
        fs_t = t;
      end
      if (vsync === 1'b0) vs_low++;
      if (px_v(t) == 100) req_on = 1;
      if (ack_m) acked = 1;
      swap_req = (px_v(t) == 50 && px_h(t) < 10) || (req_on && !acked);
    end
    swap_req = 1'b0;
    total++;
    if (acks != 1) begin
      bad++;
      $display("FAIL swap_ack_count got=%0d want=1", acks);
    end
    total++;
    if (front_sel !== 1'b1 || rd_buf !== 1'b1) begin
      bad++;
      $display("FAIL front_after got=%b%b want=11", front_sel, rd_buf);
    end
    total++;
    if (fs_n != 1 || fs_t != FRAME) begin
      bad++;
      $display("FAIL frame_start got=%0d@%0d want=1@%0d", fs_n, fs_t, FRAME);
    end
    total++;
    if (vs_low != 2 * 800 * D) begin
      bad++;
      $display("FAIL vsync_low got=%0d want=%0d", vs_low, 2 * 800 * D);
    end
  endtask

  initial begin
    key = int'($urandom_range(0, 15));
    test_reset();
    test_sync_lines();
    test_pixels();
    test_reset_midframe();
    test_swap_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Display-side reader for the framebuffer that the rasterizer writes. It generates 640x480@60 VGA timing from a divided system clock and issues one framebuffer read per visible pixel. Each 4-bit pixel index it reads is converted to 12-bit RGB. It also owns front/back buffer selection, swapping buffers only at the start of vertical blanking on request from the rendering side.

## Interface
Parameters:
- CLK_DIV, 2: clk cycles per pixel; must be >= 2.

Ports:
- clk  in  1  system clock
- areset  in  1  reset, synchronous, active-high
- rd_x  out  10  framebuffer read column
- rd_y  out  10  framebuffer read row
- rd_buf  out  1  framebuffer bank to read; equals front_sel
- rd_data  in  4  pixel index; valid 1 clk after address
- swap_req  in  1  level request to swap front/back; held until swap_ack
- swap_ack  out  1  1-clk pulse, swap performed
- front_sel  out  1  bank currently displayed
- frame_start  out  1  1-clk pulse at the pixel tick where h=0, v=0
- vblank  out  1  high while v_cnt >= 480
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- pal_we  in  1  palette write strobe
- pal_idx  in  4  palette entry
- pal_data  in  12  palette RGB

## Operation
- Divider div counts 0..CLK_DIV-1. pix_en is high when div == CLK_DIV-1.
- h_cnt runs 0..799 and advances on pix_en. At 799 it wraps to 0 and v_cnt advances; v_cnt runs 0..524 and wraps to 0.
- Horizontal regions: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical regions: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- visible = (h_cnt < 640) && (v_cnt < 480).
- rd_x = h_cnt[9:0] and rd_y = v_cnt[9:0], driven combinationally and held for the whole pixel period. rd_x/rd_y are 0 when not visible.
- Output stage updates on pix_en:
  - rgb <= visible ? map(rd_data) : 0
  - hsync <= !(656 <= h_cnt <= 751)
  - vsync <= !(490 <= v_cnt <= 491)
- vblank is registered with the same alignment as hsync/vsync.
- Buffer swap: on the pix_en where the counters move into h=0, v=480, if swap_req=1 then front_sel toggles and swap_ack=1 for that one clk. Otherwise nothing happens.
- A swap_req that arrives after that tick waits for the next frame.
- swap_req asserted and deasserted without an ack is ignored.
- frame_start pulses on the pix_en where the counters move into h=0, v=0.

## Timing
- Reset values (the clk after areset=1): div=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, rgb=0, vblank=0, front_sel=0, swap_ack=0, frame_start=0. Palette returns to defaults.
- areset mid-frame or mid-swap aborts immediately. No swap_ack is issued and scanout restarts at pixel (0,0).
- Read latency: address is stable at least CLK_DIV-1 clks before it is sampled on pix_en, which covers the 1-clk RAM latency.
- Pixel latency: the value on rgb/hsync/vsync during a pixel period reflects the counters of the previous pixel period.
- Period lengths: line = 800*CLK_DIV clk; frame = 525 lines.
- Simultaneous pal_we and a pixel sample of the same entry: the old entry value is used, and the new value applies from the next clk.
- rd_data is ignored during blanking.

## Configuration
- PALETTE_EN defined: 16x12 register palette, map(i) = pal[i].
  - Written when pal_we=1: pal[pal_idx] <= pal_data.
  - Reset value pal[i] = {i,i,i}.
- PALETTE_EN undefined: map(i) = {i,i,i}. pal_we, pal_idx and pal_data are present but ignored, and no palette storage exists.

## Test plan
- Reset, CLK_DIV=2, run 2 lines:
  - hsync low for exactly 192 clk per line.
  - Falling edges of hsync are 1600 clk apart.
  - vsync low for 2 lines (3200 clk) once per 840000 clk.
- Counters at h=5, v=7: rd_x=5, rd_y=7. Drive rd_data=4'hA the next clk. In the following pixel period rgb=12'hAAA.
- Counters at h=700, rd_data=4'hF: rgb=0. Likewise rgb=0 throughout v=480..524.
- swap_req=1 at v=100:
  - front_sel stays 0 until the counters enter v=480, h=0.
  - Then front_sel=1 and swap_ack=1 for exactly 1 clk.
  - rd_buf=1 from then on. Drop swap_req; no further toggles.
- PALETTE_EN: write pal[3]=12'hF00, then scan rd_data=3: rgb=12'hF00. Without the macro the same stimulus gives rgb=12'h333.
- areset=1 for 1 clk at h=300, v=200 while swap_req=1:
  - Next clk: h=v=0, hsync=vsync=1, rgb=0, front_sel=0, no swap_ack.
  - frame_start pulses at the end of the first full frame.
